if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and the decode stage. Captures (pc, instruction)
//  pairs from fetch, buffers up to DEPTH entries, and presents them to decode in order with a
//  valid/ready handshake. Decouples fetch from decode stalls and discards all buffered entries
//  on a taken-branch flush. Presents the canonical NOP on its outputs whenever it is empty.
// PARAMETERS
//  XLEN       32            width of pc and instruction words
//  DEPTH      4             number of entries; power of two, >= 2
//  NOP_INSTR  32'h00000013  instruction word driven on out_instr when out_valid=0
// PORTS
//  clk        in   1               rising-edge clock; single clock domain
//  rst        in   1               asynchronous, active-high reset
//  flush      in   1               taken-branch flush (driven by isBranchTaken), synchronous
//  in_valid   in   1               fetch presents a valid entry
//  in_ready   out  1               queue accepts an entry this cycle
//  in_pc      in   XLEN            pc of the fetched instruction
//  in_instr   in   XLEN            fetched instruction word
//  out_valid  out  1               head entry valid for decode
//  out_ready  in   1               decode consumes head entry this cycle
//  out_pc     out  XLEN            pc of head entry
//  out_instr  out  XLEN            instruction of head entry
//  count      out  $clog2(DEPTH)+1 number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1,
//    out_pc=0, out_instr=NOP_INSTR. Storage array contents are not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at posedge clk.
//  - in_ready = (count != DEPTH); combinational from registered count only (no path from out_ready).
//  - out_valid = (count != 0); first-word-fall-through: head entry visible combinationally.
//  - Latency: entry pushed at edge N is on out_* after edge N (1 cycle) when queue was empty.
//  - Empty: out_valid=0, out_pc=0, out_instr=NOP_INSTR (gated, not raw storage).
//  - Full: in_ready=0; push is impossible even if pop occurs the same cycle (no pass-through).
//  - Simultaneous push & pop with 0<count<DEPTH: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count tracks full vs empty.
//  - Ordering: strict FIFO; out_pc sequence equals accepted in_pc sequence.
//  - flush=1 at an edge: next state count=0, wr_ptr=rd_ptr=0; any same-cycle push and pop are
//    discarded (pop is still treated as consumed by decode; no entry is replayed).
//    flush has priority over push/pop. in_ready is not gated by flush.
//  - Reset mid-operation: all entries lost immediately on rst assertion; outputs take reset
//    values asynchronously.
//  - in_pc/in_instr are sampled only on push; value ignored otherwise (X tolerated).
// STRUCTURE
//  - Shared package pipeline_pkg: XLEN, NOP_INSTR, and typedef fetch_pkt_t {pc, instr}.
//  - One sub-module: if_id_queue_mem, DEPTH x (2*XLEN) register array, 1 write port
//    (we, waddr, wdata), 1 async read port (raddr -> rdata); no reset on the array.
//  - Top holds pointers, count, handshake logic and output gating.
// TESTING
//  1 Reset: rst=1 mid-stream -> out_valid=0, count=0, in_ready=1, out_instr=0x00000013 at once.
//  2 Fill: out_ready=0, push pc 0x0,0x4,0x8,0xC -> count=4, in_ready=0; 5th in_valid not taken;
//    then out_ready=1 -> out_pc 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0.
//  3 Streaming: in_valid=out_ready=1 continuously, pc 0x0..0x3C -> count stays 1, out_pc lags
//    in_pc by one cycle, no gaps after first entry.
//  4 Wrap: 10 push/pop cycles with count oscillating 2..3 -> pointers wrap past DEPTH-1, order
//    preserved (scoreboard compare pc and instr).
//  5 Flush: count=3, flush=1 with in_valid=1 pc 0x20 -> next cycle count=0, out_valid=0;
//    following push of pc 0x20 appears on out_pc one cycle later.
//  6 Full + pop same cycle: count=4, out_ready=1, in_valid=1 -> in_ready=0, count becomes 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline definitions: word width, canonical NOP and
// the (pc, instr) packet carried between fetch and decode.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch/decode queue: one synchronous write port and
// one asynchronous read port, contents deliberately not reset.
module if_id_queue_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2 * XLEN,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: FWFT FIFO with valid/ready on
// both sides, flush on taken branch, NOP presented while empty.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned     XLEN      = pipeline_pkg::XLEN,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] rdata;

    // Handshake depends only on registered occupancy, so full blocks a push
    // even when decode pops in the same cycle.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Empty queue shows a clean NOP rather than stale storage.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = rdata[2*XLEN-1:XLEN];
            out_instr = rdata[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_if_id_queue;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc = '0;
    logic [XLEN-1:0]  in_instr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_instr;
    logic [2:0]       count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    fetch_pkt_t mq[$];

    if_id_queue #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference: a queue of accepted packets; flush empties it, reset empties it at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            automatic bit do_push = in_valid && (mq.size() < DEPTH);
            automatic bit do_pop  = out_ready && (mq.size() != 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back('{pc: in_pc, instr: in_instr});
            end
        end
    end

    always @(negedge clk) begin
        check("m_count", 32'(count), 32'(mq.size()));
        check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        check("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("m_out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
        check("m_out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : NOP_INSTR);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Fill to capacity while decode stalls, then a refused 5th entry.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_instr = $urandom;
            cyc();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        in_pc = 32'h10;
        cyc();
        check("fill_5th_count", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fill_order_pc", out_pc, 32'(4 * i));
            cyc();
        end
        check("fill_empty_valid", 32'(out_valid), 32'd0);
        check("fill_empty_instr", out_instr, 32'h0000_0013);
        check("fill_empty_pc", out_pc, 32'h0);
        idle();

        // Reset in the middle of traffic must clear outputs immediately.
        in_valid = 1'b1;
        in_pc    = 32'h100;
        cyc();
        in_pc    = 32'h104;
        cyc();
        idle();
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_instr", out_instr, 32'h0000_0013);
        cyc();
        rst = 1'b0;

        // Streaming: one in, one out every cycle after the first.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_pc    = 32'(4 * i);
            in_instr = $urandom;
            cyc();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", out_pc, 32'(4 * i));
        end
        drain();

        // Wrap: occupancy alternates 2/3 so pointers run past DEPTH-1.
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc    = 32'h200 + 32'(4 * i);
            in_instr = $urandom;
            cyc();
        end
        for (int k = 0; k < 10; k++) begin
            in_valid  = (k % 2 == 0);
            out_ready = (k % 2 == 1);
            in_pc     = 32'h208 + 32'(4 * k);
            in_instr  = $urandom;
            cyc();
            check("wrap_count", 32'(count), (k % 2 == 0) ? 32'd3 : 32'd2);
        end
        drain();

        // Flush with a same-cycle push: both discarded, later push shows up normally.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc    = 32'h300 + 32'(4 * i);
            in_instr = $urandom;
            cyc();
        end
        check("flush_pre_count", 32'(count), 32'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'h20;
        in_instr  = 32'hdead_beef;
        cyc();
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'h1234_5678;
        cyc();
        check("flush_after_pc", out_pc, 32'h20);
        check("flush_after_instr", out_instr, 32'h1234_5678);
        drain();

        // Full with pop in the same cycle: no pass-through.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pc    = 32'h400 + 32'(4 * i);
            in_instr = $urandom;
            cyc();
        end
        out_ready = 1'b1;
        in_pc     = 32'h410;
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        cyc();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_pc", out_pc, 32'h404);
        drain();

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_pc     = $urandom;
            in_instr  = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            cyc();
        end
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
